phys_reg_free_list: RTL and testbench
=====================================

Name: phys_reg_free_list

Overview:
- Multi-ported circular free list of physical register numbers (PRNs) for the rename stage.
- Grants up to ALLOC_W PRNs per cycle to rename and accepts up to REL_W freed PRNs per cycle from commit.
- Keeps a committed head pointer so a pipeline flush returns all speculatively allocated PRNs in one cycle.

Parameters:
- NUM_A_REGS, 32: architectural registers. PRNs 0..NUM_A_REGS-1 are the initial mappings and are never in the list at reset.
- NUM_P_REGS, 48: physical registers. DEPTH = NUM_P_REGS - NUM_A_REGS and must be a power of two (default 16).
- ALLOC_W, 2: allocation lanes per cycle (1..4).
- REL_W, 2: release lanes per cycle (1..4).
- Derived: PRN_WIDTH = $clog2(NUM_P_REGS); PTR_W = $clog2(DEPTH)+1, where the MSB is a wrap bit; CNT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- alloc_req  in  ALLOC_W  per-lane request. Lanes must be contiguous from lane 0.
- alloc_gnt  out  1  all requested lanes granted this cycle.
- alloc_prn  out  ALLOC_W*PRN_WIDTH  lane i = entry[head+i]. Valid when alloc_gnt=1.
- rel_valid  in  REL_W  per-lane release valid (lanes may be sparse).
- rel_prn  in  REL_W*PRN_WIDTH  PRN to return per lane.
- commit_cnt  in  $clog2(ALLOC_W+1)  number of oldest allocations retired this cycle.
- flush  in  1  squash all speculative allocations.
- free_count  out  CNT_W  registered free-entry count.
- empty  out  1  free_count==0.
- overflow_err  out  1  sticky; a release was attempted while the list was full.
- dup_err  out  1  sticky; a duplicate release was detected (optional feature).

Behaviour:
- Reset:
  - entry[i] = NUM_A_REGS+i; head=0; commit_head=0; tail=DEPTH (wrap bit set).
  - free_count=DEPTH; all error flags 0; alloc_gnt=0 while rst is high.
- Allocate:
  - n = popcount(alloc_req).
  - alloc_gnt = (n!=0) & (free_count>=n) & !flush. The decision is all-or-nothing.
  - alloc_prn is combinational from head in the same cycle.
  - On grant, head += n at the clock edge.
  - A non-contiguous alloc_req pattern is illegal and flagged by a simulation assertion.
- Release:
  - Valid lanes are compacted in lane order and written at tail, tail..tail+k-1, wrapping modulo DEPTH.
  - rel_prn==0 or rel_prn>=NUM_P_REGS is dropped silently and does not count toward k.
  - If free_count - n_granted + k > DEPTH, the excess lanes (highest lane index first) are dropped and overflow_err is set.
- Same-cycle interaction: PRNs released in a cycle are not allocatable until the next cycle. Grant uses the registered free_count.
- Commit:
  - commit_head += commit_cnt.
  - commit_cnt must not exceed head - commit_head; violation is a simulation assertion.
- Flush:
  - head <= commit_head + commit_cnt (the same-cycle commit is applied first).
  - No grant in the flush cycle; releases in that cycle are still accepted.
- free_count:
  - Next value = tail_next - head_next, computed with the wrap bit; full when equal to DEPTH.
  - It is registered and is not a combinational function of the inputs.
- Pointer wrap: all pointers are PTR_W bits and increment modulo 2*DEPTH. Ordering is exact across the wrap.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). In-flight grants are discarded.

Optional Feature:
- Macro FL_DUP_CHECK_EN.
- Defined:
  - A NUM_P_REGS-bit is_free vector is maintained: set on accepted release, cleared on grant, reset to 1 for PRNs NUM_A_REGS..NUM_P_REGS-1.
  - A flush sets the bits of all squashed PRNs (entries head_old-1 down to the restored head).
  - Releasing a PRN whose bit is already set, or releasing the same PRN on two lanes in one cycle, drops that lane and sets dup_err.
- Undefined: no vector is built; dup_err is tied to 0; duplicates are stored.

Test Plan:
- Reset, then alloc_req=2'b11 -> alloc_gnt=1, alloc_prn={33,32}; next cycle free_count=14.
- Allocate 16 PRNs over 8 cycles, then alloc_req=2'b01 -> alloc_gnt=0, empty=1. Release PRN 40 -> next cycle free_count=1, and alloc_req=2'b01 yields alloc_prn=40.
- free_count=1 with alloc_req=2'b11 -> alloc_gnt=0 (no partial grant); head unchanged.
- Allocate 6 PRNs, commit_cnt=2 once, then flush -> next cycle free_count=DEPTH-2 and the next grant returns the 3rd allocated PRN (34).
- Full list with rel_valid=2'b01, rel_prn=45 -> PRN dropped, overflow_err=1, free_count stays 16.
- With FL_DUP_CHECK_EN: allocate 32, release 32 on both lanes in the same cycle -> one PRN stored, dup_err=1, free_count=DEPTH.

Source files
------------

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register numbers with multi-lane allocate/release
// and a committed head for one-cycle flush recovery. Define FL_DUP_CHECK_EN for duplicate-release detection.
module phys_reg_free_list #(
  parameter int NUM_A_REGS = 32,
  parameter int NUM_P_REGS = 48,
  parameter int ALLOC_W    = 2,
  parameter int REL_W      = 2,
  localparam int DEPTH     = NUM_P_REGS - NUM_A_REGS,
  localparam int PRN_WIDTH = $clog2(NUM_P_REGS),
  localparam int PTR_W     = $clog2(DEPTH) + 1,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int CC_W      = $clog2(ALLOC_W + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ALLOC_W-1:0]             alloc_req,
  output logic                           alloc_gnt,
  output logic [ALLOC_W*PRN_WIDTH-1:0]   alloc_prn,
  input  logic [REL_W-1:0]               rel_valid,
  input  logic [REL_W*PRN_WIDTH-1:0]     rel_prn,
  input  logic [CC_W-1:0]                commit_cnt,
  input  logic                           flush,
  output logic [CNT_W-1:0]               free_count,
  output logic                           empty,
  output logic                           overflow_err,
  output logic                           dup_err
);

  localparam int IDX_W = PTR_W - 1;

  logic [PRN_WIDTH-1:0] entry [DEPTH];
  logic [PTR_W-1:0]     head, commit_head, tail;
  logic [PTR_W-1:0]     head_next, commit_next, tail_next;
  logic [CNT_W-1:0]     free_count_q, room, k;
  logic [CC_W-1:0]      n_req, n_g;
  logic                 gnt, ovf_q, ovf_set;
  logic [PRN_WIDTH-1:0] gnt_prn [ALLOC_W];
  logic [REL_W-1:0]     wr_en;
  logic [PRN_WIDTH-1:0] wr_prn [REL_W];
  logic [IDX_W-1:0]     wr_idx [REL_W];

`ifdef FL_DUP_CHECK_EN
  logic [NUM_P_REGS-1:0] is_free;
  logic                  dup_q, dup_set, dup_hit;
  logic [PTR_W-1:0]      squash_n;
`endif

  always_comb begin
    n_req = '0;
    for (int unsigned i = 0; i < ALLOC_W; i++) begin
      n_req = n_req + CC_W'(alloc_req[i]);
      gnt_prn[i] = entry[head[IDX_W-1:0] + IDX_W'(i)];
      alloc_prn[i*PRN_WIDTH +: PRN_WIDTH] = gnt_prn[i];
    end
    gnt         = !rst && !flush && (n_req != '0) && (free_count_q >= CNT_W'(n_req));
    n_g         = gnt ? n_req : '0;
    commit_next = commit_head + PTR_W'(commit_cnt);
    head_next   = flush ? commit_next : head + PTR_W'(n_g);
  end

  // Lanes are compacted in order; capacity is counted against the post-grant occupancy,
  // so once room runs out every later lane is dropped.
  always_comb begin
    room    = CNT_W'(DEPTH) - (free_count_q - CNT_W'(n_g));
    k       = '0;
    ovf_set = 1'b0;
    wr_en   = '0;
`ifdef FL_DUP_CHECK_EN
    dup_set = 1'b0;
    dup_hit = 1'b0;
`endif
    for (int unsigned i = 0; i < REL_W; i++) begin
      wr_prn[i] = rel_prn[i*PRN_WIDTH +: PRN_WIDTH];
      wr_idx[i] = tail[IDX_W-1:0] + IDX_W'(k);
      if (rel_valid[i] && (wr_prn[i] != '0) &&
          ({1'b0, wr_prn[i]} < (PRN_WIDTH+1)'(NUM_P_REGS))) begin
`ifdef FL_DUP_CHECK_EN
        dup_hit = is_free[wr_prn[i]];
        for (int unsigned j = 0; j < i; j++)
          if (wr_en[j] && (wr_prn[j] == wr_prn[i])) dup_hit = 1'b1;
        if (dup_hit) dup_set = 1'b1;
        else
`endif
        if (k >= room) ovf_set = 1'b1;
        else begin
          wr_en[i] = 1'b1;
          k        = k + 1'b1;
        end
      end
    end
    tail_next = tail + PTR_W'(k);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        entry[i] <= PRN_WIDTH'(NUM_A_REGS + i);
      head         <= '0;
      commit_head  <= '0;
      tail         <= PTR_W'(DEPTH);
      free_count_q <= CNT_W'(DEPTH);
      ovf_q        <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < REL_W; i++)
        if (wr_en[i]) entry[wr_idx[i]] <= wr_prn[i];
      head         <= head_next;
      commit_head  <= commit_next;
      tail         <= tail_next;
      free_count_q <= CNT_W'(tail_next - head_next);
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

`ifdef FL_DUP_CHECK_EN
  assign squash_n = head - commit_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_P_REGS; p++)
        is_free[p] <= (p >= NUM_A_REGS);
      dup_q <= 1'b0;
    end else begin
      if (gnt)
        for (int unsigned i = 0; i < ALLOC_W; i++)
          if (alloc_req[i]) is_free[gnt_prn[i]] <= 1'b0;
      if (flush)
        for (int unsigned j = 0; j < DEPTH; j++)
          if (PTR_W'(j) < squash_n)
            is_free[entry[commit_next[IDX_W-1:0] + IDX_W'(j)]] <= 1'b1;
      for (int unsigned i = 0; i < REL_W; i++)
        if (wr_en[i]) is_free[wr_prn[i]] <= 1'b1;
      if (dup_set) dup_q <= 1'b1;
    end
  end

  assign dup_err = dup_q;
`else
  assign dup_err = 1'b0;
`endif

  assign alloc_gnt    = gnt;
  assign free_count   = free_count_q;
  assign empty        = (free_count_q == '0);
  assign overflow_err = ovf_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((alloc_req & (alloc_req + ALLOC_W'(1))) == '0)
        else $error("non-contiguous alloc_req %b", alloc_req);
      assert (PTR_W'(commit_cnt) <= PTR_W'(head - commit_head))
        else $error("commit_cnt %0d exceeds outstanding allocations", commit_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: a vector table over a wrap-around sequence
// plus hand-written corner-case sequences (flush, overflow, duplicates, async reset).
module tb_phys_reg_free_list;
  localparam int PW = 6;
`ifdef FL_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    alloc_req = '0;
  logic          alloc_gnt;
  logic [2*PW-1:0] alloc_prn;
  logic [1:0]    rel_valid = '0;
  logic [2*PW-1:0] rel_prn = '0;
  logic [1:0]    commit_cnt = '0;
  logic          flush = 1'b0;
  logic [4:0]    free_count;
  logic          empty, overflow_err, dup_err;

  int n_cmp = 0;
  int n_bad = 0;

  phys_reg_free_list #(.NUM_A_REGS(32), .NUM_P_REGS(48), .ALLOC_W(2), .REL_W(2)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_prn(alloc_prn),
    .rel_valid(rel_valid), .rel_prn(rel_prn), .commit_cnt(commit_cnt), .flush(flush),
    .free_count(free_count), .empty(empty), .overflow_err(overflow_err), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req, rv;
    int p0, p1, cc;
    bit fl, g;
    int e0, e1, fc;
    bit ovf;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic vec(input string tag, input logic [1:0] req, input logic [1:0] rv,
                     input int p0, input int p1, input int cc, input bit fl, input bit g,
                     input int e0, input int e1, input int fc, input bit ovf);
    @(negedge clk);
    alloc_req  = req;
    rel_valid  = rv;
    rel_prn    = {PW'(p1), PW'(p0)};
    commit_cnt = 2'(cc);
    flush      = fl;
    #1;
    chk({tag, " gnt"}, int'(alloc_gnt), int'(g));
    if (g) begin
      chk({tag, " prn0"}, int'(alloc_prn[PW-1:0]), e0);
      if (req[1]) chk({tag, " prn1"}, int'(alloc_prn[2*PW-1:PW]), e1);
    end
    @(posedge clk);
    #1;
    chk({tag, " free_count"}, int'(free_count), fc);
    chk({tag, " empty"}, int'(empty), int'(fc == 0));
    chk({tag, " overflow_err"}, int'(overflow_err), int'(ovf));
    alloc_req  = '0;
    rel_valid  = '0;
    commit_cnt = '0;
    flush      = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst       = 1'b1;
    alloc_req = 2'b11;
    rel_valid = '0;
    flush     = 1'b0;
    commit_cnt = '0;
    #1;
    chk({tag, " rst gnt"}, int'(alloc_gnt), 0);
    chk({tag, " rst free_count"}, int'(free_count), 16);
    chk({tag, " rst empty"}, int'(empty), 0);
    chk({tag, " rst overflow_err"}, int'(overflow_err), 0);
    chk({tag, " rst dup_err"}, int'(dup_err), 0);
    @(negedge clk);
    rst       = 1'b0;
    alloc_req = '0;
  endtask

  initial begin
    //          req    rv     p0 p1 cc fl    g     e0  e1  fc ovf
    tbl[0]  = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 32, 33, 14, 1'b0};
    tbl[1]  = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 34, 35, 12, 1'b0};
    tbl[2]  = '{2'b01, 2'b00, 0, 0, 0, 1'b0, 1'b1, 36, 0,  11, 1'b0};
    tbl[3]  = '{2'b00, 2'b00, 0, 0, 2, 1'b0, 1'b0, 0,  0,  11, 1'b0};
    tbl[4]  = '{2'b11, 2'b00, 0, 0, 1, 1'b1, 1'b0, 0,  0,  13, 1'b0};
    tbl[5]  = '{2'b01, 2'b00, 0, 0, 0, 1'b0, 1'b1, 35, 0,  12, 1'b0};
    tbl[6]  = '{2'b11, 2'b11, 33, 0, 0, 1'b0, 1'b1, 36, 37, 11, 1'b0};
    tbl[7]  = '{2'b00, 2'b10, 0, 50, 0, 1'b0, 1'b0, 0, 0,  11, 1'b0};
    tbl[8]  = '{2'b00, 2'b11, 1, 2, 0, 1'b0, 1'b0, 0,  0,  13, 1'b0};
    tbl[9]  = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 38, 39, 11, 1'b0};
    tbl[10] = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 40, 41, 9,  1'b0};
    tbl[11] = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 42, 43, 7,  1'b0};
    tbl[12] = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 44, 45, 5,  1'b0};
    tbl[13] = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 46, 47, 3,  1'b0};
    tbl[14] = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 33, 1,  1,  1'b0};
    tbl[15] = '{2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b0, 0,  0,  1,  1'b0};
    tbl[16] = '{2'b01, 2'b00, 0, 0, 0, 1'b0, 1'b1, 2,  0,  0,  1'b0};
    tbl[17] = '{2'b01, 2'b00, 0, 0, 0, 1'b0, 1'b0, 0,  0,  0,  1'b0};
    tbl[18] = '{2'b00, 2'b01, 3, 0, 0, 1'b0, 1'b0, 0,  0,  1,  1'b0};
    tbl[19] = '{2'b01, 2'b00, 0, 0, 0, 1'b0, 1'b1, 3,  0,  0,  1'b0};

    repeat (2) @(posedge clk);
    do_reset("tbl");
    for (int i = 0; i < 20; i++)
      vec($sformatf("v%0d", i), tbl[i].req, tbl[i].rv, tbl[i].p0, tbl[i].p1, tbl[i].cc,
          tbl[i].fl, tbl[i].g, tbl[i].e0, tbl[i].e1, tbl[i].fc, tbl[i].ovf);

    // drain all 16, then release single PRNs and check all-or-nothing grant
    do_reset("drain");
    for (int c = 0; c < 8; c++)
      vec($sformatf("drain%0d", c), 2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1,
          32 + 2*c, 33 + 2*c, 14 - 2*c, 1'b0);
    vec("empty_req",  2'b01, 2'b00, 0,  0, 0, 1'b0, 1'b0, 0,  0, 0, 1'b0);
    vec("rel40",      2'b00, 2'b01, 40, 0, 0, 1'b0, 1'b0, 0,  0, 1, 1'b0);
    vec("get40",      2'b01, 2'b00, 0,  0, 0, 1'b0, 1'b1, 40, 0, 0, 1'b0);
    vec("rel41",      2'b00, 2'b01, 41, 0, 0, 1'b0, 1'b0, 0,  0, 1, 1'b0);
    vec("no_partial", 2'b11, 2'b00, 0,  0, 0, 1'b0, 1'b0, 0,  0, 1, 1'b0);
    vec("get41",      2'b01, 2'b00, 0,  0, 0, 1'b0, 1'b1, 41, 0, 0, 1'b0);

    // six allocations, commit two, flush restores the other four
    do_reset("flush");
    vec("fa0",   2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 32, 33, 14, 1'b0);
    vec("fa1",   2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 34, 35, 12, 1'b0);
    vec("fa2",   2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 36, 37, 10, 1'b0);
    vec("fcmt",  2'b00, 2'b00, 0, 0, 2, 1'b0, 1'b0, 0,  0,  10, 1'b0);
    vec("fflsh", 2'b01, 2'b00, 0, 0, 0, 1'b1, 1'b0, 0,  0,  14, 1'b0);
    vec("fnext", 2'b01, 2'b00, 0, 0, 0, 1'b0, 1'b1, 34, 0,  13, 1'b0);

    // release into a full list
    do_reset("full");
    vec("full45", 2'b00, 2'b01, 45, 0, 0, 1'b0, 1'b0, 0, 0, 16, !DUP);
    chk("full45 dup_err", int'(dup_err), int'(DUP));
    vec("full_sticky", 2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b0, 0, 0, 16, !DUP);

    // grant frees one slot; the higher of two releases is dropped
    do_reset("cap");
    vec("cap", 2'b01, 2'b11, 5, 6, 0, 1'b0, 1'b1, 32, 0, 16, 1'b1);

    // same PRN released on both lanes
    do_reset("dup");
    vec("dup_a", 2'b01, 2'b00, 0,  0,  0, 1'b0, 1'b1, 32, 0, 15, 1'b0);
    vec("dup_r", 2'b00, 2'b11, 32, 32, 0, 1'b0, 1'b0, 0,  0, 16, !DUP);
    chk("dup_r dup_err", int'(dup_err), int'(DUP));

    // asynchronous reset in the middle of a cycle
    do_reset("async");
    vec("as_a", 2'b11, 2'b00, 0, 0, 0, 1'b0, 1'b1, 32, 33, 14, 1'b0);
    @(negedge clk);
    alloc_req = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    chk("async free_count", int'(free_count), 16);
    chk("async gnt", int'(alloc_gnt), 0);
    chk("async empty", int'(empty), 0);
    @(negedge clk);
    rst       = 1'b0;
    alloc_req = '0;
    vec("as_b", 2'b01, 2'b00, 0, 0, 0, 1'b0, 1'b1, 32, 0, 15, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
